// File: rtl/onebit_pkg.sv
// Shared definitions for the one-bit processor and its program loader.
// INSTR_W and PROG_DEPTH are shared with onebitprocessor, so changing them
// here changes the instruction format and memory depth on both sides.
// loader_state_t enumerates the loader sequencing states.
package onebit_pkg;

  localparam int INSTR_W    = 13;
  localparam int PROG_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    GAP   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

endpackage

// File: rtl/prog_buffer.sv
// Program buffer: DEPTH x WIDTH register file with one synchronous write
// port and one combinational read port. Contents are never cleared.
// Ports:
//   clk   - system clock
//   we    - write strobe
//   waddr - write slot (slots at or beyond DEPTH are ignored)
//   wdata - word to store
//   raddr - read slot
//   rdata - word stored at raddr (0 for slots at or beyond DEPTH)
module prog_buffer #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 13,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Range check keeps non-power-of-two depths from aliasing onto real slots.
  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(raddr) < DEPTH) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/prog_stream_loader.sv
// Writer side of the processor's serial instruction-load interface.
// Host logic fills a small program buffer in parallel; on start the loader
// pulses the processor reset, waits one cycle, then streams num_instr words
// MSB-first, one bit per clock, with load enable held continuously.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   wr_en, wr_addr, wr_data - buffer write port (ignored while busy)
//   num_instr   - word count to stream, sampled with start, clamped to depth
//   start       - begin the reset-and-load sequence
//   busy        - sequence in progress
//   done        - one-cycle completion pulse
//   ser_rst, ser_en, ser_data - processor reset, load enable, serial bit
module prog_stream_loader #(
  parameter int INSTR_W    = onebit_pkg::INSTR_W,
  parameter int PROG_DEPTH = onebit_pkg::PROG_DEPTH,
  parameter int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [ADDR_W:0]    num_instr,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ser_rst,
  output logic               ser_en,
  output logic               ser_data
);

  import onebit_pkg::*;

  localparam int BIT_W = $clog2(INSTR_W);

  loader_state_t      state;
  logic [ADDR_W:0]    n_words;
  logic [ADDR_W-1:0]  word_idx;
  logic [BIT_W-1:0]   bit_idx;
  logic [INSTR_W-1:0] shift_reg;
  logic [ADDR_W-1:0]  rd_addr;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W:0]    n_clamped;
  logic               last_word;

  prog_buffer #(
    .DEPTH  (PROG_DEPTH),
    .WIDTH  (INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // While shifting, the read port looks one word ahead so the next word is
  // ready at the word boundary; in GAP it presents slot 0.
  always_comb begin
    rd_addr   = '0;
    if (state == SHIFT) begin
      rd_addr = word_idx + ADDR_W'(1);
    end
    n_clamped = num_instr;
    if (num_instr > (ADDR_W+1)'(PROG_DEPTH)) begin
      n_clamped = (ADDR_W+1)'(PROG_DEPTH);
    end
    last_word = ({1'b0, word_idx} == (n_words - (ADDR_W+1)'(1)));
  end

  // ser_data is registered one bit ahead: when a word is loaded its MSB goes
  // straight to ser_data and the shift register keeps the remaining bits
  // left-aligned, so bit_idx names the bit currently on the wire.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_rst   <= 1'b0;
      ser_en    <= 1'b0;
      ser_data  <= 1'b0;
      n_words   <= '0;
      word_idx  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      done    <= 1'b0;
      ser_rst <= 1'b0;
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          ser_en   <= 1'b0;
          ser_data <= 1'b0;
          if (start) begin
            n_words <= n_clamped;
            ser_rst <= 1'b1;
            busy    <= 1'b1;
            state   <= RST;
          end
        end
        RST: begin
          state <= GAP;
        end
        GAP: begin
          word_idx <= '0;
          bit_idx  <= BIT_W'(INSTR_W-1);
          if (n_words == '0) begin
            shift_reg <= rd_data;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end else begin
            shift_reg <= rd_data << 1;
            ser_data  <= rd_data[INSTR_W-1];
            ser_en    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_idx == '0) begin
            if (last_word) begin
              ser_en   <= 1'b0;
              ser_data <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              word_idx  <= word_idx + ADDR_W'(1);
              bit_idx   <= BIT_W'(INSTR_W-1);
              ser_data  <= rd_data[INSTR_W-1];
              shift_reg <= rd_data << 1;
            end
          end else begin
            bit_idx   <= bit_idx - BIT_W'(1);
            ser_data  <= shift_reg[INSTR_W-1];
            shift_reg <= shift_reg << 1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed testbench for prog_stream_loader: checks reset state, sequence
// timing, serial bit order, count clamping, zero-length loads, interference
// during shifting, and mid-sequence reset recovery.
module tb_prog_stream_loader;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [12:0] wr_data;
  logic [4:0]  num_instr;
  logic        start;
  logic        busy;
  logic        done;
  logic        ser_rst;
  logic        ser_en;
  logic        ser_data;

  int testsRun;
  int testsFailed;

  logic [12:0] model [16];
  bit          stream [256];

  prog_stream_loader dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .num_instr (num_instr),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ser_rst   (ser_rst),
    .ser_en    (ser_en),
    .ser_data  (ser_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic writeWord(input int addr, input logic [12:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr[3:0];
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
    model[addr] = data;
  endtask

  // Starts a load of num words (expN after clamping) and records every cycle
  // at the falling edge. Cycle k=1 is the first cycle after start is sampled.
  // If injectAt > 0, start and a write to slot 2 are asserted at that cycle.
  task automatic applyStimulus(input int num, input int expN, input int injectAt);
    int rstCycle, rstCount, enFirst, enCount, enGaps;
    int doneCycle, doneCount, busyCount, dataLeak, bound;
    bit lastEn, seenEn;
    logic [12:0] word;
    rstCycle = 0; rstCount = 0; enFirst = 0; enCount = 0; enGaps = 0;
    doneCycle = 0; doneCount = 0; busyCount = 0; dataLeak = 0;
    lastEn = 1'b0; seenEn = 1'b0;
    bound = 13 * expN + 8;
    @(negedge clk);
    num_instr = num[4:0];
    start     = 1'b1;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (ser_rst) begin
        rstCount++;
        if (rstCycle == 0) rstCycle = k;
      end
      if (ser_en) begin
        if (!seenEn) enFirst = k;
        if (seenEn && !lastEn) enGaps++;
        seenEn = 1'b1;
        if (enCount < 256) stream[enCount] = ser_data;
        enCount++;
      end else if (ser_data) begin
        dataLeak++;
      end
      lastEn = ser_en;
      if (done) begin
        doneCount++;
        doneCycle = k;
      end
      if (busy) busyCount++;
      start = 1'b0;
      wr_en = 1'b0;
      if (k == injectAt) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        wr_data = ~model[2];
      end
    end
    start = 1'b0;
    wr_en = 1'b0;
    checkOutput($sformatf("n%0d rst_cycle", num), rstCycle, 1);
    checkOutput($sformatf("n%0d rst_count", num), rstCount, 1);
    checkOutput($sformatf("n%0d en_count", num), enCount, 13 * expN);
    if (expN > 0) begin
      checkOutput($sformatf("n%0d en_first", num), enFirst, 3);
      checkOutput($sformatf("n%0d en_gaps", num), enGaps, 0);
    end
    checkOutput($sformatf("n%0d data_leak", num), dataLeak, 0);
    checkOutput($sformatf("n%0d done_count", num), doneCount, 1);
    checkOutput($sformatf("n%0d done_cycle", num), doneCycle, 13 * expN + 3);
    checkOutput($sformatf("n%0d busy_count", num), busyCount, 13 * expN + 2);
    for (int w = 0; w < expN; w++) begin
      word = '0;
      for (int b = 0; b < 13; b++) begin
        word = {word[11:0], stream[13 * w + b]};
      end
      checkOutput($sformatf("n%0d word%0d", num, w), {19'd0, word}, {19'd0, model[w]});
    end
  endtask

  initial begin
    int doneSeen;
    testsRun    = 0;
    testsFailed = 0;
    reset     = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    num_instr = '0;
    start     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ser_rst", ser_rst, 0);
    checkOutput("reset ser_en", ser_en, 0);
    checkOutput("reset ser_data", ser_data, 0);
    reset = 1'b0;

    writeWord(0, 13'h1FFF);
    applyStimulus(1, 1, 0);

    writeWord(0, 13'h1555);
    writeWord(1, 13'h0AAA);
    applyStimulus(2, 2, 0);

    for (int i = 0; i < 16; i++) begin
      writeWord(i, 13'((i * 13'h0155) & 13'h1FFF));
    end
    applyStimulus(16, 16, 0);
    applyStimulus(20, 16, 0);
    applyStimulus(0, 0, 0);

    applyStimulus(4, 4, 20);

    // Abort a load at word 3, bit 5 (cycle 3 + 39 + 7 = 49).
    @(negedge clk);
    num_instr = 5'd8;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (48) @(negedge clk);
    checkOutput("abort pre ser_en", ser_en, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort ser_en", ser_en, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    doneSeen = 0;
    repeat (120) begin
      @(negedge clk);
      if (done || busy || ser_en) doneSeen++;
    end
    checkOutput("abort quiet", doneSeen, 0);
    applyStimulus(4, 4, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
